// File: rtl/seq_mult_pkg.sv
// Shared types and width helpers for the iterative shift-add multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Product, accumulator and shifted multiplicand all share this width.
    function automatic int prod_width(input int wa, input int wb);
        return wa + wb;
    endfunction

    // Iteration counter must reach WA itself, hence WA+1 distinct values.
    function automatic int cnt_width(input int wa);
        return $clog2(wa + 1);
    endfunction

endpackage

// File: rtl/seq_mult_abs.sv
// Combinational two's-complement magnitude; the most negative value maps to 2^(W-1) as an unsigned number.
module seq_mult_abs #(
    parameter int W = 8
) (
    input  logic [W-1:0] value,
    input  logic         is_signed,
    output logic [W-1:0] magnitude
);

    assign magnitude = (is_signed && value[W-1]) ? -value : value;

endmodule

// File: rtl/seq_mult_param.sv
// Iterative shift-add multiplier: one multiplier bit per RUN cycle, sign applied once in FIX.
// Handshake: a request is taken on a rising edge where start && ready; ready is high in IDLE and DONE.
module seq_mult_param
    import seq_mult_pkg::*;
#(
    parameter int WA         = 8,
    parameter int WB         = 8,
    parameter int EARLY_EXIT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WA-1:0]    a,
    input  logic [WB-1:0]    b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WA+WB-1:0] product
);

    localparam int PW = prod_width(WA, WB);
    localparam int CW = cnt_width(WA);
    localparam logic [CW-1:0] CNT_LAST = CW'(WA);

    state_t         state;
    state_t         state_next;
    logic [WA-1:0]  a_mag;
    logic [WB-1:0]  b_mag;
    logic [WA-1:0]  mplier;
    logic [PW-1:0]  mcand;
    logic [PW-1:0]  acc;
    logic [CW-1:0]  cnt;
    logic           neg;
    logic           accept;
    logic           run_stop;

    seq_mult_abs #(.W(WA)) u_abs_a (.value(a), .is_signed(is_signed), .magnitude(a_mag));
    seq_mult_abs #(.W(WB)) u_abs_b (.value(b), .is_signed(is_signed), .magnitude(b_mag));

    assign accept   = start && ready;
    assign run_stop = (cnt == CNT_LAST) || ((EARLY_EXIT != 0) && (mplier == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake outputs depend on the state register alone; start only steers the next state.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (run_stop) state_next = FIX;
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                ready      = 1'b1;
                done       = 1'b1;
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mplier <= '0;
            mcand  <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
        end else if (accept) begin
            mplier <= a_mag;
            mcand  <= PW'(b_mag);
            acc    <= '0;
            cnt    <= '0;
            neg    <= is_signed & (a[WA-1] ^ b[WB-1]);
        end else if (state == RUN && !run_stop) begin
            acc    <= acc + (mplier[0] ? mcand : '0);
            mplier <= mplier >> 1;
            mcand  <= mcand << 1;
            cnt    <= cnt + CW'(1);
        end
    end

    // Product only moves on the FIX edge so it holds the last result between operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product <= '0;
        end else if (state == FIX) begin
            product <= neg ? -acc : acc;
        end
    end

`ifdef FORMAL
    logic [WA-1:0] f_amag;
    logic [WB-1:0] f_bmag;
    logic          f_signed;
    logic [WA-1:0] f_amask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_amag   <= '0;
            f_bmag   <= '0;
            f_signed <= 1'b0;
        end else if (accept) begin
            f_amag   <= a_mag;
            f_bmag   <= b_mag;
            f_signed <= is_signed;
        end
    end

    localparam logic [PW-1:0] UMAX = PW'({WA{1'b1}}) * PW'({WB{1'b1}});
    assign f_amask = ~({WA{1'b1}} << cnt);

    a_umax: assert property (@(posedge clk) disable iff (!rst_n)
        (state == DONE && !f_signed) |-> product <= UMAX);
    a_done: assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);
    a_acc: assert property (@(posedge clk) disable iff (!rst_n)
        (state == RUN) |-> acc == PW'(f_amag & f_amask) * PW'(f_bmag));
    a_cnt: assert property (@(posedge clk) disable iff (!rst_n)
        (state == RUN && !run_stop) |=> cnt == $past(cnt) + CW'(1));
`endif

endmodule

// File: tb/tb_seq_mult_param.sv
// Bench for seq_mult_param: one instance with EARLY_EXIT=0 (inst 0) and one with EARLY_EXIT=1 (inst 1).
module tb_seq_mult_param;

    localparam int WA = 8;
    localparam int WB = 8;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    logic          start0, sgn0, ready0, busy0, done0;
    logic [WA-1:0] a0;
    logic [WB-1:0] b0;
    logic [PW-1:0] prod0;
    logic          start1, sgn1, ready1, busy1, done1;
    logic [WA-1:0] a1;
    logic [WB-1:0] b1;
    logic [PW-1:0] prod1;

    int n_tests = 0;
    int n_fail  = 0;
    logic [PW-1:0] exp_q[$];

    seq_mult_param #(.WA(WA), .WB(WB), .EARLY_EXIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .is_signed(sgn0), .a(a0), .b(b0),
        .ready(ready0), .busy(busy0), .done(done0), .product(prod0)
    );

    seq_mult_param #(.WA(WA), .WB(WB), .EARLY_EXIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .is_signed(sgn1), .a(a1), .b(b1),
        .ready(ready1), .busy(busy1), .done(done1), .product(prod1)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // done pulse counters and back-to-back done detection
    int   dcnt0 = 0, dcnt1 = 0, dbl0 = 0, dbl1 = 0;
    logic pd0 = 1'b0, pd1 = 1'b0;
    always @(negedge clk) begin
        if (done0) dcnt0++;
        if (done1) dcnt1++;
        if (done0 && pd0) dbl0++;
        if (done1 && pd1) dbl1++;
        pd0 = done0;
        pd1 = done1;
    end

    // ---------------- reference model ----------------
    function automatic logic [PW-1:0] ref_prod(input logic sg, input logic [WA-1:0] av,
                                               input logic [WB-1:0] bv);
        int x, y;
        if (sg) begin
            x = $signed(av);
            y = $signed(bv);
        end else begin
            x = int'(av);
            y = int'(bv);
        end
        return PW'(x * y);
    endfunction

    function automatic int ref_lat(input bit ee, input logic sg, input logic [WA-1:0] av);
        int m, k;
        if (!ee) return WA + 2;
        if (sg) m = $signed(av);
        else    m = int'(av);
        if (m < 0) m = -m;
        if (m == 0) return 2;
        k = 0;
        for (int i = 0; i < WA + 1; i++) if (((m >> i) & 1) != 0) k = i;
        return k + 3;
    endfunction

    // ---------------- driver tasks ----------------
    function automatic logic get_done(input int inst);
        return (inst == 0) ? done0 : done1;
    endfunction

    function automatic logic [PW-1:0] get_prod(input int inst);
        return (inst == 0) ? prod0 : prod1;
    endfunction

    task automatic drive(input int inst, input logic s, input logic sg,
                         input logic [WA-1:0] av, input logic [WB-1:0] bv);
        if (inst == 0) begin
            start0 = s; sgn0 = sg; a0 = av; b0 = bv;
        end else begin
            start1 = s; sgn1 = sg; a1 = av; b1 = bv;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called right after the acceptance edge; optionally pulses start mid-RUN.
    task automatic wait_done(input int inst, input int exp_lat, input string name, input bit poke);
        int k = 0;
        bit got = 1'b0;
        logic [PW-1:0] e;
        while (!got && k < 40) begin
            @(posedge clk);
            k++;
            #1;
            got = get_done(inst);
            if (poke && k == 3) drive(inst, 1'b1, 1'b0, 8'd7, 8'd7);
            if (poke && k == 4) drive(inst, 1'b0, 1'b0, 8'd7, 8'd7);
        end
        e = exp_q.pop_front();
        if (!got) begin
            check({name, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({name, "_lat"}, k, exp_lat);
            check({name, "_prod"}, 32'(get_prod(inst)), 32'(e));
        end
    endtask

    task automatic run_op(input int inst, input logic sg, input logic [WA-1:0] av,
                          input logic [WB-1:0] bv, input logic [PW-1:0] exp_p,
                          input int exp_lat, input string name, input bit poke);
        @(negedge clk);
        drive(inst, 1'b1, sg, av, bv);
        @(posedge clk);
        #1;
        drive(inst, 1'b0, sg, av, bv);
        exp_q.push_back(exp_p);
        wait_done(inst, exp_lat, name, poke);
    endtask

    typedef struct {
        int            inst;
        logic          sg;
        logic [WA-1:0] av;
        logic [WB-1:0] bv;
        logic [PW-1:0] p;
        int            lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int d;
        logic          sg;
        logic [WA-1:0] av;
        logic [WB-1:0] bv;

        drive(0, 1'b0, 1'b0, 8'd0, 8'd0);
        drive(1, 1'b0, 1'b0, 8'd0, 8'd0);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready0", ready0, 1'b1);
        check("rst_busy0", busy0, 1'b0);
        check("rst_done0", done0, 1'b0);
        check("rst_prod0", prod0, 16'h0);
        check("rst_ready1", ready1, 1'b1);
        check("rst_busy1", busy1, 1'b0);
        check("rst_done1", done1, 1'b0);
        check("rst_prod1", prod1, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed table: expected values written from the arithmetic directly
        vecs.push_back('{0, 1'b0, 8'd255, 8'd255, 16'hFE01, 10});
        vecs.push_back('{0, 1'b1, 8'h80,  8'h80,  16'h4000, 10});
        vecs.push_back('{0, 1'b1, 8'hFD,  8'd5,   16'hFFF1, 10});
        vecs.push_back('{0, 1'b0, 8'd0,   8'd0,   16'h0000, 10});
        vecs.push_back('{0, 1'b1, 8'd127, 8'h80,  16'hC080, 10});
        vecs.push_back('{0, 1'b1, 8'hFF,  8'hFF,  16'h0001, 10});
        vecs.push_back('{1, 1'b0, 8'd1,   8'd9,   16'h0009, 3});
        vecs.push_back('{1, 1'b0, 8'd0,   8'd77,  16'h0000, 2});
        vecs.push_back('{1, 1'b0, 8'd255, 8'd255, 16'hFE01, 10});
        vecs.push_back('{1, 1'b1, 8'h80,  8'd3,   16'hFE80, 10});
        vecs.push_back('{1, 1'b1, 8'hFD,  8'd5,   16'hFFF1, 4});
        vecs.push_back('{1, 1'b0, 8'd16,  8'd16,  16'h0100, 7});
        for (int i = 0; i < vecs.size(); i++)
            run_op(vecs[i].inst, vecs[i].sg, vecs[i].av, vecs[i].bv, vecs[i].p, vecs[i].lat,
                   $sformatf("vec%0d", i), 1'b0);

        // start pulsed during RUN must not disturb the running operation
        d = dcnt0;
        run_op(0, 1'b0, 8'd12, 8'd10, 16'd120, 10, "busy_start", 1'b1);
        repeat (4) @(negedge clk);
        check("busy_start_single_done", dcnt0 - d, 1);
        check("busy_start_idle", ready0, 1'b1);

        // back-to-back: start presented during the DONE cycle
        run_op(0, 1'b0, 8'd5, 8'd5, 16'd25, 10, "b2b_first", 1'b0);
        check("b2b_done_ready", ready0, 1'b1);
        check("b2b_done_busy", busy0, 1'b0);
        drive(0, 1'b1, 1'b0, 8'd2, 8'd3);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 8'd2, 8'd3);
        exp_q.push_back(16'd6);
        wait_done(0, WA + 2, "b2b_second", 1'b0);

        // asynchronous reset in the middle of RUN (cnt=4)
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 8'd200, 8'd100);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 8'd200, 8'd100);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", ready0, 1'b1);
        check("midrst_busy", busy0, 1'b0);
        check("midrst_done", done0, 1'b0);
        check("midrst_prod", prod0, 16'h0);
        d = dcnt0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("midrst_no_done", dcnt0 - d, 0);
        check("midrst_prod_held", prod0, 16'h0);
        run_op(0, 1'b0, 8'd200, 8'd100, 16'd20000, 10, "midrst_restart", 1'b0);

        // randomized operations against the reference model
        for (int i = 0; i < 30; i++) begin
            sg = 1'($urandom_range(0, 1));
            av = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) av = 8'd0;
            bv = 8'($urandom_range(0, 255));
            run_op(0, sg, av, bv, ref_prod(sg, av, bv), ref_lat(1'b0, sg, av),
                   $sformatf("rnd0_%0d", i), 1'b0);
            sg = 1'($urandom_range(0, 1));
            av = 8'($urandom_range(0, 255) >> $urandom_range(0, 7));
            bv = 8'($urandom_range(0, 255));
            run_op(1, sg, av, bv, ref_prod(sg, av, bv), ref_lat(1'b1, sg, av),
                   $sformatf("rnd1_%0d", i), 1'b0);
        end

        repeat (3) @(negedge clk);
        check("no_double_done0", dbl0, 0);
        check("no_double_done1", dbl1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
